// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR sequencer: FSM state encoding and
// default width / tap constants.
package lfsr_pkg;

  localparam int unsigned LFSR_WIDTH_DEF = 4;
  localparam int unsigned LFSR_CNTW_DEF  = 8;
  // x^4 + x^3 + 1: maximal length (period 15) for the default width
  localparam logic [LFSR_WIDTH_DEF-1:0] LFSR_TAPS_DEF = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } lfsr_state_t;

endpackage

// File: rtl/lfsr_core.sv
// WIDTH-bit Fibonacci LFSR register with load and shift enables.
// Ports:
//   clk, rst       clock, async active-high reset (q -> 0)
//   load, seed     load seed into q (has priority over shift)
//   shift          advance one step: q <= {q[WIDTH-2:0], ^(q & TAPS)}
//   q              current register value
//   q_next_c       combinational value q would take on a shift
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = LFSR_WIDTH_DEF,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_next_c
);

  // Next value: shift left, feedback enters at bit 0
  assign q_next_c = {q[WIDTH-2:0], ^(q & TAPS)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= seed;
    end else if (shift) begin
      q <= q_next_c;
    end
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// LFSR run sequencer: captures a seed/step count on start, loads the LFSR,
// shifts for a fixed number of steps (or until stop in free-run mode) and
// reports completion, zero-seed error and period detection.
// Ports:
//   clk, rst                 clock, async active-high reset
//   start, seed, steps,      run request and its parameters (sampled in IDLE)
//   free_run
//   stop                     abort / terminate a run (honoured in RUN only)
//   q, bit_out               LFSR state and its MSB
//   busy                     high in LOAD and RUN
//   done                     one-cycle pulse in DONE
//   seed_err                 captured seed was zero (held until next start)
//   period_hit               pulse after a shift that returns q to the seed
//   step_cnt                 shifts performed, saturating
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = LFSR_WIDTH_DEF,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_TAPS_DEF),
  parameter int unsigned      CNTW  = LFSR_CNTW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNTW-1:0]  steps,
  input  logic             free_run,
  input  logic             stop,
  output logic [WIDTH-1:0] q,
  output logic             bit_out,
  output logic             busy,
  output logic             done,
  output logic             seed_err,
  output logic             period_hit,
  output logic [CNTW-1:0]  step_cnt
);

  lfsr_state_t      state, state_nxt;
  logic [WIDTH-1:0] seed_r;
  logic [CNTW-1:0]  steps_r;
  logic             free_run_r;

  logic             accept_c;
  logic             load_en_c;
  logic             shift_en_c;
  logic             seed_zero_c;
  logic [CNTW-1:0]  steps_last_c;
  logic [WIDTH-1:0] q_next_c;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load_en_c),
    .shift    (shift_en_c),
    .seed     (seed_r),
    .q        (q),
    .q_next_c (q_next_c)
  );

  assign bit_out      = q[WIDTH-1];
  assign seed_zero_c  = (seed_r == '0);
  // step_cnt value at which the upcoming shift is the final one
  assign steps_last_c = steps_r - CNTW'(1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath enables
  always_comb begin
    state_nxt  = state;
    accept_c   = 1'b0;
    load_en_c  = 1'b0;
    shift_en_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept_c  = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_en_c = 1'b1;
        if (seed_zero_c || (steps_r == '0 && !free_run_r)) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // stop wins over a coinciding final shift
        if (stop) begin
          state_nxt = ST_DONE;
        end else begin
          shift_en_c = 1'b1;
          if (!free_run_r && step_cnt == steps_last_c) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Captured run parameters, counter and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_r     <= '0;
      steps_r    <= '0;
      free_run_r <= 1'b0;
      step_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      seed_err   <= 1'b0;
      period_hit <= 1'b0;
    end else begin
      busy       <= (state_nxt == ST_LOAD) || (state_nxt == ST_RUN);
      done       <= (state_nxt == ST_DONE);
      period_hit <= shift_en_c && (q_next_c == seed_r);

      if (accept_c) begin
        seed_r     <= seed;
        steps_r    <= steps;
        free_run_r <= free_run;
        seed_err   <= 1'b0;
      end

      if (load_en_c) begin
        step_cnt <= '0;
        seed_err <= seed_zero_c;
      end else if (shift_en_c && step_cnt != '1) begin
        step_cnt <= step_cnt + CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl with default parameters
// (WIDTH=4, TAPS=4'b1100, CNTW=8).
module tb_lfsr_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] seed;
  logic [7:0] steps;
  logic       free_run;
  logic       stop;
  logic [3:0] q;
  logic       bit_out;
  logic       busy;
  logic       done;
  logic       seed_err;
  logic       period_hit;
  logic [7:0] step_cnt;

  int errors = 0;
  int checks = 0;

  // Hand-computed orbit of seed 0001 under x^4+x^3+1; index = shifts mod 15
  logic [3:0] orbit [0:14] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
                               4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
                               4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

  lfsr_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .seed       (seed),
    .steps      (steps),
    .free_run   (free_run),
    .stop       (stop),
    .q          (q),
    .bit_out    (bit_out),
    .busy       (busy),
    .done       (done),
    .seed_err   (seed_err),
    .period_hit (period_hit),
    .step_cnt   (step_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a start request for one edge (E0); returns just after E0
  task automatic start_run(input logic [3:0] s, input logic [7:0] n, input logic fr);
    start    = 1'b1;
    seed     = s;
    steps    = n;
    free_run = fr;
    tick();
    start    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; seed = '0; steps = '0; free_run = 1'b0; stop = 1'b0;

    // Reset state
    #3;
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_seed_err", 32'(seed_err), 32'h0);
    chk("rst_period_hit", 32'(period_hit), 32'h0);
    chk("rst_step_cnt", 32'(step_cnt), 32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Seed 0001, 3 steps: q 0001,0010,0100,1001; done after E4
    start_run(4'b0001, 8'd3, 1'b0);
    chk("t1_e0_busy", 32'(busy), 32'h1);
    chk("t1_e0_q_unchanged", 32'(q), 32'h0);
    tick();
    chk("t1_e1_q", 32'(q), 32'b0001);
    chk("t1_e1_cnt", 32'(step_cnt), 32'd0);
    chk("t1_e1_busy", 32'(busy), 32'h1);
    tick();
    chk("t1_e2_q", 32'(q), 32'b0010);
    chk("t1_e2_busy", 32'(busy), 32'h1);
    tick();
    chk("t1_e3_q", 32'(q), 32'b0100);
    chk("t1_e3_busy", 32'(busy), 32'h1);
    chk("t1_e3_done", 32'(done), 32'h0);
    tick();
    chk("t1_e4_q", 32'(q), 32'b1001);
    chk("t1_e4_bit_out", 32'(bit_out), 32'h1);
    chk("t1_e4_done", 32'(done), 32'h1);
    chk("t1_e4_busy", 32'(busy), 32'h0);
    chk("t1_e4_cnt", 32'(step_cnt), 32'd3);
    tick();
    chk("t1_e5_done", 32'(done), 32'h0);
    chk("t1_e5_q_hold", 32'(q), 32'b1001);
    chk("t1_e5_cnt_hold", 32'(step_cnt), 32'd3);

    // Free run from 0001, stop after 20 shifts; period_hit after shift 15
    start_run(4'b0001, 8'd0, 1'b1);
    tick();
    chk("t2_load_q", 32'(q), 32'b0001);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("t2_q_shift%0d", k), 32'(q), 32'(orbit[k % 15]));
      chk($sformatf("t2_ph_shift%0d", k), 32'(period_hit), 32'(k == 15));
    end
    chk("t2_cnt20", 32'(step_cnt), 32'd20);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t2_stop_done", 32'(done), 32'h1);
    chk("t2_stop_q", 32'(q), 32'b0110);
    chk("t2_stop_cnt", 32'(step_cnt), 32'd20);
    tick();

    // Zero seed: LOAD goes straight to DONE with seed_err
    start_run(4'b0000, 8'd5, 1'b0);
    tick();
    chk("t3_done", 32'(done), 32'h1);
    chk("t3_seed_err", 32'(seed_err), 32'h1);
    chk("t3_q", 32'(q), 32'h0);
    chk("t3_cnt", 32'(step_cnt), 32'd0);
    chk("t3_busy", 32'(busy), 32'h0);
    tick();
    chk("t3_idle_done", 32'(done), 32'h0);
    chk("t3_idle_seed_err_held", 32'(seed_err), 32'h1);

    // Seed 1000, 0 steps; stop held high outside RUN has no effect
    stop = 1'b1;
    start_run(4'b1000, 8'd0, 1'b0);
    chk("t4_seed_err_cleared", 32'(seed_err), 32'h0);
    chk("t4_e0_done", 32'(done), 32'h0);
    tick();
    stop = 1'b0;
    chk("t4_done", 32'(done), 32'h1);
    chk("t4_q", 32'(q), 32'b1000);
    chk("t4_cnt", 32'(step_cnt), 32'd0);
    tick();

    // start during RUN with another seed is ignored
    start_run(4'b0001, 8'd3, 1'b0);
    tick();
    start = 1'b1; seed = 4'b0101; steps = 8'd7;
    tick();
    start = 1'b0;
    chk("t5_e2_q", 32'(q), 32'b0010);
    tick();
    chk("t5_e3_q", 32'(q), 32'b0100);
    tick();
    chk("t5_e4_q", 32'(q), 32'b1001);
    chk("t5_e4_done", 32'(done), 32'h1);
    chk("t5_e4_cnt", 32'(step_cnt), 32'd3);
    tick();
    chk("t5_idle_busy", 32'(busy), 32'h0);

    // stop coinciding with the final shift: no shift, step_cnt = steps-1
    start_run(4'b0001, 8'd3, 1'b0);
    tick(); tick(); tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t6_done", 32'(done), 32'h1);
    chk("t6_q", 32'(q), 32'b0100);
    chk("t6_cnt", 32'(step_cnt), 32'd2);
    tick();

    // Async reset mid-RUN, then a fresh run
    start_run(4'b0001, 8'd5, 1'b0);
    tick(); tick();
    chk("t7_pre_rst_q", 32'(q), 32'b0010);
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_q", 32'(q), 32'h0);
    chk("t7_rst_busy", 32'(busy), 32'h0);
    chk("t7_rst_cnt", 32'(step_cnt), 32'h0);
    tick();
    chk("t7_rst_done", 32'(done), 32'h0);
    #2 rst = 1'b0;
    tick();
    chk("t7_post_done", 32'(done), 32'h0);
    chk("t7_post_busy", 32'(busy), 32'h0);
    start_run(4'b0001, 8'd3, 1'b0);
    tick(); tick(); tick(); tick();
    chk("t7_rerun_q", 32'(q), 32'b1001);
    chk("t7_rerun_done", 32'(done), 32'h1);
    chk("t7_rerun_cnt", 32'(step_cnt), 32'd3);
    tick();

    // step_cnt saturates in free run: 300 shifts -> 255, q back to seed
    start_run(4'b0001, 8'd0, 1'b1);
    tick();
    repeat (300) tick();
    chk("t8_cnt_sat_running", 32'(step_cnt), 32'd255);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t8_done", 32'(done), 32'h1);
    chk("t8_cnt_sat", 32'(step_cnt), 32'd255);
    chk("t8_q", 32'(q), 32'b0001);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lfsr_seq_ctrl.md
LFSR_SEQ_CTRL -- requirements
Module: lfsr_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: LFSR register width, legal range 3..16.
REQ-002 Parameter TAPS, default 4'b1100 (WIDTH bits): feedback mask, with feedback = XOR-reduce(q & TAPS).
REQ-003 Parameter CNTW, default 8: width of the step-count input and step counter.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  request a run; sampled only in IDLE.
REQ-007 seed  in  WIDTH  initial LFSR value; captured with start.
REQ-008 steps  in  CNTW  number of shifts to perform; captured with start.
REQ-009 free_run  in  1  run until stop (steps ignored); captured with start.
REQ-010 stop  in  1  abort or terminate a run; honoured in RUN only.
REQ-011 q  out  WIDTH  current LFSR state.
REQ-012 bit_out  out  1  serial output, equal to q[WIDTH-1].
REQ-013 busy  out  1  high in LOAD and RUN.
REQ-014 done  out  1  single-cycle pulse, high in DONE.
REQ-015 seed_err  out  1  high in DONE when the captured seed was all-zero; cleared at the next accepted start.
REQ-016 period_hit  out  1  single-cycle pulse when a RUN shift returns q to the captured seed.
REQ-017 step_cnt  out  CNTW  shifts performed in the current or last run; saturates at all-ones.

Function
REQ-018 The shift SHALL be q_next = {q[WIDTH-2:0], ^(q & TAPS)}, one shift per clk in RUN only.
REQ-019 The FSM SHALL have states IDLE, LOAD, RUN and DONE, with IDLE as the reset state.
REQ-020 IDLE -> LOAD on an edge with start=1, capturing seed, steps and free_run into internal registers; q is unchanged.
REQ-021 LOAD SHALL, on the next edge, set q to the captured seed, clear step_cnt and seed_err, and then transition:
  - to DONE with seed_err=1 if the seed is zero;
  - otherwise to DONE if steps==0 and free_run==0;
  - otherwise to RUN.
REQ-022 RUN SHALL shift and increment step_cnt on each edge; it goes to DONE on the edge performing shift number `steps` (free_run=0), or on the first edge with stop=1, in which case no shift occurs on that edge.
REQ-023 If stop and the final shift coincide, stop SHALL win: no shift occurs and step_cnt = steps-1.
REQ-024 DONE SHALL last exactly one cycle and then return to IDLE; q and step_cnt hold their values through DONE and IDLE.
REQ-025 Latency for non-zero seed, steps=N>0, free_run=0: done SHALL be high in the cycle after edge E(N+1), where E0 is the start-sampling edge.
REQ-026 start SHALL be ignored outside IDLE, and stop SHALL be ignored outside RUN.
REQ-027 period_hit SHALL be registered and asserted in the cycle after a RUN shift whose result equals the captured seed; with default parameters and a non-zero seed this occurs every 15 shifts.
REQ-028 step_cnt SHALL saturate rather than wrap in free_run mode.

Reset
REQ-029 While rst=1, the block SHALL enter IDLE immediately, regardless of clk.
REQ-030 Reset values: q=0, step_cnt=0, busy=0, done=0, seed_err=0, period_hit=0, and all captured registers=0.
REQ-031 Reset during LOAD or RUN SHALL abandon the run with no done pulse.

Structure
REQ-032 A shared package lfsr_pkg SHALL hold the FSM state typedef, the default TAPS constant and the default WIDTH/CNTW constants.
REQ-033 A single sub-module, lfsr_core, SHALL hold the WIDTH-bit register with load/shift enables and async reset; lfsr_seq_ctrl holds the FSM, counter and flags.

Verification
REQ-034 Seed=4'b0001, steps=3, free_run=0 -> q sequence 0001, 0010, 0100, 1001; done in cycle E4+1; step_cnt=3; busy high for 4 cycles.
REQ-035 Seed=4'b0001, free_run=1, stop after 20 shifts -> period_hit pulses after shift 15; q=0100 after shift 17 (sequence restarted); step_cnt=20.
REQ-036 Seed=4'b0000, steps=5 -> LOAD goes straight to DONE; seed_err=1; q=0000; step_cnt=0.
REQ-037 Seed=4'b1000, steps=0 -> q=1000, done two edges after start, no shifts.
REQ-038 start pulsed during RUN with a different seed -> ignored; the current run completes unchanged.
REQ-039 rst asserted mid-RUN between clock edges -> q=0 and busy=0 immediately, no done pulse; a new start afterwards behaves per REQ-034.
